// File: rtl/mmio_responder.sv
// MMIO responder for the Riscv151 core: decodes loads/stores in the MMIO
// window and serves the UART (RX FIFO, one TX holding byte) plus the
// cycle and retired-instruction counters. Load data is registered so it
// arrives one cycle after re, matching the synchronous memories.
//
// Handshakes (tx_valid/tx_ready, rx_valid/rx_ready) are strict valid/ready:
// a transfer happens on a rising clk edge where both valid and ready are 1;
// valid never waits on ready, and ready here is derived only from registered
// state (tx_valid = holding full, rx_ready = !fifo full).
module mmio_responder #(
  parameter logic [3:0] MMIO_BASE = 4'h8,
  parameter int         RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] RX_FULL_COUNT = CW'(RX_DEPTH);

  // Word index of each register (offset >> 2)
  localparam logic [5:0] IDX_STATUS = 6'h00;
  localparam logic [5:0] IDX_RX     = 6'h01;
  localparam logic [5:0] IDX_TX     = 6'h02;
  localparam logic [5:0] IDX_CYCLE  = 6'h04;
  localparam logic [5:0] IDX_INST   = 6'h05;
  localparam logic [5:0] IDX_CRST   = 6'h06;

  logic        sel;
  logic [5:0]  reg_idx;
  logic        load;
  logic        store;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop;

  logic        tx_full;
  logic        tx_accept;
  logic        tx_done;

  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic        cnt_clr;

  logic [31:0] rd_mux;

  // Upper offset bits, byte lane bits and store data above the byte are
  // intentionally ignored by this block.
  logic unused_bits;
  assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};

  assign sel     = (addr[31:28] == MMIO_BASE);
  assign reg_idx = addr[7:2];
  assign load    = re & sel;
  assign store   = sel & (|wea);

  assign rx_full   = (rx_count == RX_FULL_COUNT);
  assign rx_empty  = (rx_count == '0);
  assign rx_ready  = !rx_full;
  assign rx_push   = rx_valid & !rx_full;
  assign rx_pop    = load & (reg_idx == IDX_RX) & !rx_empty;

  assign tx_valid  = tx_full;
  assign tx_accept = store & (reg_idx == IDX_TX) & !tx_full;
  assign tx_done   = tx_full & tx_ready;

  assign cnt_clr   = store & (reg_idx == IDX_CRST);

  // RX FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // RX FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX holding register; a store only lands when the holder was empty at the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_full <= 1'b0;
      tx_data <= 8'h00;
    end else if (tx_accept) begin
      tx_full <= 1'b1;
      tx_data <= wdata[7:0];
    end else if (tx_done) begin
      tx_full <= 1'b0;
    end
  end

  // Free-running counters; a counter-reset store beats any increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // Read mux over pre-edge register values
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_STATUS: rd_mux = {30'b0, !rx_empty, !tx_full};
      IDX_RX:     rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd_ptr]};
      IDX_CYCLE:  rd_mux = cycle_cnt;
      IDX_INST:   rd_mux = inst_cnt;
      default:    rd_mux = '0;
    endcase
  end

  // Load data register: captured on every re edge, zero outside the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= sel ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: UART TX/RX paths, counters, window
// decode and asynchronous reset, with hand-computed expected values.
module tb_mmio_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic        re;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks;
  int passes;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] A_INST   = 32'h8000_0014;
  localparam logic [31:0] A_CRST   = 32'h8000_0018;

  mmio_responder #(.MMIO_BASE(4'h8), .RX_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .wea         (wea),
    .re          (re),
    .inst_retire (inst_retire),
    .rdata       (rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic do_load(input logic [31:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    addr = 32'h0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wea   = 4'hf;
    tick();
    wea   = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b0;
    addr = 32'h0; wdata = 32'h0; wea = 4'h0; re = 1'b0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);
    rst = 1'b1;
    tick();

    // Status after reset, then out-of-window access
    do_load(A_STATUS);
    check("status_idle", rdata, 32'h1);
    do_load(32'h4000_0000);
    check("unselected_load", rdata, 32'h0);
    do_store(32'h0000_0008, 32'h99);
    check("unselected_store", {31'b0, tx_valid}, 32'h0);

    // TX holding: first store held, second dropped
    do_store(A_TX, 32'h41);
    check("tx_valid_set", {31'b0, tx_valid}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    do_store(A_TX, 32'h42);
    check("tx_data_kept", {24'b0, tx_data}, 32'h41);
    do_load(A_STATUS);
    check("status_tx_full", rdata, 32'h0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("tx_drained", {31'b0, tx_valid}, 32'h0);
    do_load(A_STATUS);
    check("status_tx_empty", rdata, 32'h1);

    // Store in the same cycle the handshake completes is dropped
    do_store(A_TX, 32'h41);
    tx_ready = 1'b1;
    do_store(A_TX, 32'h43);
    tx_ready = 1'b0;
    check("tx_store_on_done_valid", {31'b0, tx_valid}, 32'h0);
    check("tx_store_on_done_data", {24'b0, tx_data}, 32'h41);

    // RX FIFO fill, overflow attempt, drain
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    check("rx_ready_3", {31'b0, rx_ready}, 32'h1);
    push_rx(8'h44);
    check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    push_rx(8'h55);
    do_load(A_STATUS);
    check("status_rx_nonempty", rdata, 32'h3);
    do_load(A_RX); check("rx_pop_0", rdata, 32'h11);
    do_load(A_RX); check("rx_pop_1", rdata, 32'h22);
    do_load(A_RX); check("rx_pop_2", rdata, 32'h33);
    do_load(A_RX); check("rx_pop_3", rdata, 32'h44);
    do_load(A_RX); check("rx_pop_empty", rdata, 32'h0);
    do_load(A_STATUS);
    check("status_rx_empty", rdata, 32'h1);

    // Concurrent push/pop with 3 entries, ordering across pointer wrap
    push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3);
    rx_data = 8'h66; rx_valid = 1'b1;
    do_load(A_RX);
    rx_valid = 1'b0;
    check("rx_pushpop_head", rdata, 32'hA1);
    check("rx_pushpop_ready", {31'b0, rx_ready}, 32'h1);
    do_load(A_RX); check("rx_wrap_0", rdata, 32'hA2);
    do_load(A_RX); check("rx_wrap_1", rdata, 32'hA3);
    do_load(A_RX); check("rx_wrap_2", rdata, 32'h66);
    do_load(A_RX); check("rx_wrap_empty", rdata, 32'h0);

    // Full FIFO: a simultaneous pop does not admit a push
    push_rx(8'hB1); push_rx(8'hB2); push_rx(8'hB3); push_rx(8'hB4);
    rx_data = 8'h77; rx_valid = 1'b1;
    do_load(A_RX);
    rx_valid = 1'b0;
    check("rx_full_pop_head", rdata, 32'hB1);
    check("rx_full_pop_ready", {31'b0, rx_ready}, 32'h1);
    do_load(A_RX); check("rx_full_0", rdata, 32'hB2);
    do_load(A_RX); check("rx_full_1", rdata, 32'hB3);
    do_load(A_RX); check("rx_full_2", rdata, 32'hB4);
    do_load(A_RX); check("rx_full_no_push", rdata, 32'h0);

    // Counters: clear, 10 cycles with retire on alternate cycles
    do_store(A_CRST, 32'h1);
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
    end
    inst_retire = 1'b0;
    do_load(A_CYCLE);
    check("cycle_count_10", rdata, 32'd10);
    do_load(A_INST);
    check("inst_count_5", rdata, 32'd5);

    // Counter reset beats a concurrent retire
    inst_retire = 1'b1;
    do_store(A_CRST, 32'h0);
    inst_retire = 1'b0;
    do_load(A_CYCLE);
    check("cycle_clr_wins", rdata, 32'd0);
    do_load(A_INST);
    check("inst_clr_wins", rdata, 32'd0);

    // Store and load in one cycle: store applies, load sees pre-edge status
    addr = A_TX; wdata = 32'h5A; wea = 4'hf; re = 1'b1;
    tick();
    addr = 32'h0; wdata = 32'h0; wea = 4'h0; re = 1'b0;
    check("tx_store_load", {24'b0, tx_data}, 32'h5A);

    // Asynchronous reset mid-transfer
    push_rx(8'hC1); push_rx(8'hC2);
    do_load(A_STATUS);
    check("status_before_reset", rdata, 32'h2);
    rst = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("async_rdata", rdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    do_load(A_STATUS);
    check("status_after_reset", rdata, 32'h1);
    do_load(A_RX);
    check("rx_discarded", rdata, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
